exp3_unidade_controle: RTL and testbench

Moore control unit that sequences the exp3 datapath: address counter, key register, 4-bit comparator and 16x4 synchronous ROM. It runs one game round per key press: register the keys, compare them with the ROM word at the current address, then advance or end. It raises pronto/acertou/errou at the end and exposes its state for the 7-segment debug display.

---
 rtl/exp3_pkg.sv | 18 +
 rtl/exp3_unidade_controle_edge_detector.sv | 24 ++
 rtl/exp3_unidade_controle.sv | 141 ++++++++++++++
 tb/tb_exp3_unidade_controle.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/exp3_pkg.sv
// Shared definitions for the exp3 game: FSM state encoding and ROM depth.
package exp3_pkg;

    localparam int ROM_PROFUNDIDADE = 16;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h3,
        COMPARACAO  = 4'h4,
        PROXIMO     = 4'h5,
        FIM_ACERTOU = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERROU   = 4'hE
    } estado_t;

endpackage

// File: rtl/exp3_unidade_controle_edge_detector.sv
// Rising-edge detector: one-cycle pulso on each 0->1 transition of sinal.
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic sinal_q;
    logic sinal_d;

    assign sinal_d = sinal;

    always_ff @(posedge clock) begin
        if (reset) begin
            sinal_q <= 1'b0;
        end else begin
            sinal_q <= sinal_d;
        end
    end

    assign pulso = sinal & ~sinal_q;

endmodule

// File: rtl/exp3_unidade_controle.sv
// Moore control unit for the exp3 memory game datapath.
// Optional espera timeout is enabled by defining the TIMEOUT_EN macro.
module exp3_unidade_controle
    import exp3_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic [3:0] db_estado
);

    estado_t estado_q;
    estado_t estado_d;
    logic    jogada_pulso;
    logic    expirou;

    edge_detector u_detector_jogada (
        .clock (clock),
        .reset (reset),
        .sinal (jogada),
        .pulso (jogada_pulso)
    );

`ifdef TIMEOUT_EN
    localparam int TIMER_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;

    // Held at zero outside espera so every entry starts a fresh count.
    always_comb begin
        timer_d = '0;
        if (estado_q == ESPERA) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expirou = (timer_q == TIMER_W'(TIMEOUT_CICLOS - 1));
`else
    assign expirou = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARACAO;
            end
            PREPARACAO: begin
                estado_d = ESPERA;
            end
            ESPERA: begin
                // A key press in the expiry cycle still counts as a move.
                if (jogada_pulso)  estado_d = REGISTRA;
                else if (expirou)  estado_d = FIM_TIMEOUT;
            end
            REGISTRA: begin
                estado_d = COMPARACAO;
            end
            COMPARACAO: begin
                if (!igual)     estado_d = FIM_ERROU;
                else if (fimC)  estado_d = FIM_ACERTOU;
                else            estado_d = PROXIMO;
            end
            PROXIMO: begin
                estado_d = ESPERA;
            end
`ifdef TIMEOUT_EN
            FIM_TIMEOUT,
`endif
            FIM_ACERTOU,
            FIM_ERROU: begin
                if (iniciar) estado_d = PREPARACAO;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase
    end

    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        unique case (estado_q)
            PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            REGISTRA: registraR = 1'b1;
            PROXIMO:  contaC    = 1'b1;
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
`ifdef TIMEOUT_EN
            FIM_TIMEOUT,
`endif
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_exp3_unidade_controle.sv
// Directed self-checking bench for exp3_unidade_controle (TIMEOUT_EN section optional).
module tb_exp3_unidade_controle;

`ifdef TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 5000;
`endif

    logic       clock = 1'b0;
    logic       reset, iniciar, jogada, igual, fimC;
    logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou;
    logic [3:0] db_estado;

    int ncmp  = 0;
    int nfail = 0;
    int n_conta = 0;
    int n_reg   = 0;
    int base;
    logic [3:0] endereco;

    exp3_unidade_controle #(.TIMEOUT_CICLOS(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .jogada    (jogada),
        .igual     (igual),
        .fimC      (fimC),
        .zeraC     (zeraC),
        .contaC    (contaC),
        .zeraR     (zeraR),
        .registraR (registraR),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Address counter model standing in for the datapath.
    always @(posedge clock) begin
        if (zeraC)       endereco <= 4'd0;
        else if (contaC) endereco <= endereco + 4'd1;
        if (contaC)    n_conta <= n_conta + 1;
        if (registraR) n_reg   <= n_reg + 1;
    end
    assign fimC = (endereco == 4'd15);

    task automatic passo();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] esp);
        ncmp++;
        assert (obs === esp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, esp);
        end
    endtask

    function automatic logic [6:0] saidas();
        return {zeraC, contaC, zeraR, registraR, pronto, acertou, errou};
    endfunction

    // One round starting in espera; ends one edge after comparacao.
    task automatic rodada(input logic ok);
        jogada = 1'b1;
        passo();
        chk("registra", {4'h0, db_estado}, 8'h03);
        chk("registraR", {7'h0, registraR}, 8'h01);
        jogada = 1'b0;
        igual  = ok;
        passo();
        chk("comparacao", {4'h0, db_estado}, 8'h04);
        passo();
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0;
        endereco = 4'd0;
        passo();
        passo();
        chk("reset_estado", {4'h0, db_estado}, 8'h00);
        chk("reset_saidas", {1'b0, saidas()}, 8'h00);
        reset = 1'b0;
        passo();
        chk("inicial_espera_iniciar", {4'h0, db_estado}, 8'h00);

        // Full win
        iniciar = 1'b1;
        passo();
        chk("prep_estado", {4'h0, db_estado}, 8'h01);
        chk("prep_saidas", {1'b0, saidas()}, 8'b0101_0000);
        iniciar = 1'b0;
        passo();
        chk("espera", {4'h0, db_estado}, 8'h02);
        base = n_conta;
        for (int i = 0; i < 16; i++) begin
            rodada(1'b1);
            if (i < 15) begin
                chk("proximo", {4'h0, db_estado}, 8'h05);
                chk("contaC", {7'h0, contaC}, 8'h01);
                passo();
                chk("volta_espera", {4'h0, db_estado}, 8'h02);
            end
        end
        chk("fim_acertou", {4'h0, db_estado}, 8'h0A);
        chk("acertou_saidas", {1'b0, saidas()}, 8'b0000_0110);
        chk("conta_15", 8'(n_conta - base), 8'd15);
        passo();
        passo();
        chk("fim_acertou_mantem", {4'h0, db_estado}, 8'h0A);

        // Early miss on word 2
        iniciar = 1'b1;
        passo();
        chk("reinicio_prep", {4'h0, db_estado}, 8'h01);
        iniciar = 1'b0;
        passo();
        base = n_conta;
        rodada(1'b1); passo();
        rodada(1'b1); passo();
        rodada(1'b0);
        chk("fim_errou", {4'h0, db_estado}, 8'h0E);
        chk("errou_saidas", {1'b0, saidas()}, 8'b0000_0101);
        chk("conta_2", 8'(n_conta - base), 8'd2);
        passo();
        chk("fim_errou_mantem", {4'h0, db_estado}, 8'h0E);

        // Restart from fim_errou with iniciar held through a round
        iniciar = 1'b1;
        passo();
        chk("errou_para_prep", {4'h0, db_estado}, 8'h01);
        passo();
        chk("prep_para_espera", {4'h0, db_estado}, 8'h02);
        passo();
        chk("iniciar_ignorado_espera", {4'h0, db_estado}, 8'h02);
        rodada(1'b1);
        chk("iniciar_ignorado_proximo", {4'h0, db_estado}, 8'h05);
        passo();
        chk("iniciar_ignorado_espera2", {4'h0, db_estado}, 8'h02);
        iniciar = 1'b0;

        // Held jogada: one registration only
        base = n_reg;
        jogada = 1'b1;
        igual  = 1'b1;
        for (int c = 0; c < 20; c++) passo();
        chk("held_um_registra", 8'(n_reg - base), 8'd1);
        chk("held_fica_espera", {4'h0, db_estado}, 8'h02);
        jogada = 1'b0;
        passo();
        chk("held_solto_espera", {4'h0, db_estado}, 8'h02);
        jogada = 1'b1;
        passo();
        chk("held_nova_borda", {4'h0, db_estado}, 8'h03);
        jogada = 1'b0;
        passo();
        passo();
        passo();

        // Reset during comparacao of round 5
        reset = 1'b1;
        passo();
        reset = 1'b0;
        iniciar = 1'b1;
        passo();
        iniciar = 1'b0;
        passo();
        for (int r = 0; r < 4; r++) begin
            rodada(1'b1);
            passo();
        end
        jogada = 1'b1;
        passo();
        jogada = 1'b0;
        igual  = 1'b1;
        passo();
        chk("r5_comparacao", {4'h0, db_estado}, 8'h04);
        reset   = 1'b1;
        iniciar = 1'b1;
        passo();
        chk("reset_meio_estado", {4'h0, db_estado}, 8'h00);
        chk("reset_meio_saidas", {1'b0, saidas()}, 8'h00);
        reset = 1'b0;
        passo();
        chk("pos_reset_prep", {1'b0, saidas()}, 8'b0101_0000);
        iniciar = 1'b0;
        passo();
        chk("pos_reset_espera", {4'h0, db_estado}, 8'h02);

`ifdef TIMEOUT_EN
        // Timeout after 8 idle cycles in espera
        for (int c = 0; c < 7; c++) passo();
        chk("to_ainda_espera", {4'h0, db_estado}, 8'h02);
        passo();
        chk("to_estado", {4'h0, db_estado}, 8'h0D);
        chk("to_saidas", {1'b0, saidas()}, 8'b0000_0101);
        iniciar = 1'b1;
        passo();
        iniciar = 1'b0;
        passo();
        chk("to_reinicio_espera", {4'h0, db_estado}, 8'h02);
        for (int c = 0; c < 7; c++) passo();
        jogada = 1'b1;
        passo();
        chk("to_jogada_vence", {4'h0, db_estado}, 8'h03);
        jogada = 1'b0;
`else
        for (int c = 0; c < 12; c++) passo();
        chk("sem_timeout_espera", {4'h0, db_estado}, 8'h02);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
